// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register, next-PC selection and the IF/ID pipeline register
// with stall/flush handling, a sticky misalignment flag and a fetch counter.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  input  logic        redirect_e,
  input  logic [31:0] redirect_target_e,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  logic        jump_take;
  logic        bubble;
  logic        load;
  logic        bad_target;
  logic [31:0] seq_pc;
  logic [31:0] pc_next;
  // A jump only counts when decode holds a real, unstalled instruction; EX redirect outranks it.
  always_comb begin
    jump_take  = jump_d & valid_d & ~stall_d;
    bubble     = redirect_e | jump_take | flush_d;
    load       = ~bubble & ~stall_d;
    bad_target = (redirect_e & |redirect_target_e[1:0]) | (jump_take & |jump_target_d[1:0]);
    seq_pc     = pc_f + 32'd4;
    pc_next    = redirect_e ? {redirect_target_e[31:2], 2'b00} :
                 jump_take  ? {jump_target_d[31:2], 2'b00} :
                 stall_f    ? pc_f : seq_pc;
  end
  assign imem_addr = pc_f;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f         <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc_f         <= pc_next;
      misalign_err <= misalign_err | bad_target;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d     <= NOP_INSTR;
      pc_plus4_d  <= 32'd0;
      valid_d     <= 1'b0;
      fetch_count <= 32'd0;
    end else if (bubble) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (load) begin
      instr_d     <= imem_rdata;
      pc_plus4_d  <= seq_pc;
      valid_d     <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: table-driven directed vectors plus hand-written reset sequences.
module tb_instruction_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, jump_d = 1'b0, redirect_e = 1'b0;
  logic [31:0] jump_target_d = 32'd0, redirect_target_e = 32'd0;
  logic [31:0] pc_f, instr_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_err;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic        sf, sd, fl, j;
    logic [31:0] jt;
    logic        r;
    logic [31:0] rt, rd, pc, ins, p4;
    logic        v, mis;
    logic [31:0] fc;
  } vec_t;

  vec_t vec [18];

  instruction_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .jump_d(jump_d),
    .jump_target_d(jump_target_d), .redirect_e(redirect_e), .redirect_target_e(redirect_target_e),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] p4, input logic v, input logic mis, input logic [31:0] fc);
    chk({tag, ".pc_f"}, pc_f, pc);
    chk({tag, ".imem_addr"}, imem_addr, pc);
    chk({tag, ".instr_d"}, instr_d, ins);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, p4);
    chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, mis});
    chk({tag, ".fetch_count"}, fetch_count, fc);
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fl, input logic j, input logic [31:0] jt,
                       input logic r, input logic [31:0] rt, input logic [31:0] rd);
    stall_f = sf; stall_d = sd; flush_d = fl; jump_d = j; jump_target_d = jt;
    redirect_e = r; redirect_target_e = rt; imem_rdata = rd;
  endtask

  initial begin
    //           sf sd fl j  jt            r  rt            rd            pc            ins           p4            v  mis fc
    vec[0]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_0005, 32'h4,        32'h2001_0005, 32'h4,        1, 0, 32'd1};
    vec[1]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_0006, 32'h8,        32'h2001_0006, 32'h8,        1, 0, 32'd2};
    vec[2]  = '{1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2001_0007, 32'h8,        32'h2001_0006, 32'h8,        1, 0, 32'd2};
    vec[3]  = '{1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h2001_0007, 32'h8,        32'h2001_0006, 32'h8,        1, 0, 32'd2};
    vec[4]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_0007, 32'hC,        32'h2001_0007, 32'hC,        1, 0, 32'd3};
    vec[5]  = '{0, 0, 0, 1, 32'h40,       0, 32'h0,        32'h2001_0008, 32'h40,       32'h0,         32'h0,        0, 0, 32'd3};
    vec[6]  = '{0, 0, 0, 1, 32'h80,       0, 32'h0,        32'h2001_0009, 32'h44,       32'h2001_0009, 32'h44,       1, 0, 32'd4};
    vec[7]  = '{1, 1, 0, 1, 32'h80,       0, 32'h0,        32'h2001_00AA, 32'h44,       32'h2001_0009, 32'h44,       1, 0, 32'd4};
    vec[8]  = '{0, 0, 0, 1, 32'h40,       1, 32'h100,      32'h2001_00BB, 32'h100,      32'h0,         32'h0,        0, 0, 32'd4};
    vec[9]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_000A, 32'h104,      32'h2001_000A, 32'h104,      1, 0, 32'd5};
    vec[10] = '{1, 1, 0, 0, 32'h0,        1, 32'h200,      32'h2001_00CC, 32'h200,      32'h0,         32'h0,        0, 0, 32'd5};
    vec[11] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_000B, 32'h204,      32'h2001_000B, 32'h204,      1, 0, 32'd6};
    vec[12] = '{0, 0, 0, 1, 32'h42,       0, 32'h0,        32'h2001_00DD, 32'h40,       32'h0,         32'h0,        0, 1, 32'd6};
    vec[13] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_000C, 32'h44,       32'h2001_000C, 32'h44,       1, 1, 32'd7};
    vec[14] = '{0, 0, 0, 1, 32'h80,       0, 32'h0,        32'h2001_00EE, 32'h80,       32'h0,         32'h0,        0, 1, 32'd7};
    vec[15] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h2001_00FF, 32'h84,       32'h0,         32'h0,        0, 1, 32'd7};
    vec[16] = '{0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'h2001_0111, 32'hFFFF_FFFC, 32'h0,         32'h0,        0, 1, 32'd7};
    vec[17] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h2001_000D, 32'h0,        32'h2001_000D, 32'h0,        1, 1, 32'd8};
    #12;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      drive(vec[i].sf, vec[i].sd, vec[i].fl, vec[i].j, vec[i].jt, vec[i].r, vec[i].rt, vec[i].rd);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vec[i].pc, vec[i].ins, vec[i].p4, vec[i].v, vec[i].mis, vec[i].fc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0101, 32'h1234_5678);
    @(posedge clk);
    #1;
    chk_all("redir_misalign", 32'h100, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk_all("after_redir", 32'h104, 32'hDEAD_BEEF, 32'h104, 1'b1, 1'b1, 32'd1);
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0, 32'hCAFE_0001);
    @(posedge clk);
    #1;
    chk_all("stall_d_only", 32'h108, 32'hDEAD_BEEF, 32'h104, 1'b1, 1'b1, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front of the 6-stage pipeline.
- Holds the PC and drives the instruction-memory address.
- Selects the next PC: sequential, decode-stage jump, or execute-stage branch redirect.
- Owns the IF/ID pipeline register feeding instruction_code into the decode stage; handles stall and flush from the hazard unit and keeps a sticky misalignment flag and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word written into IF/ID on flush (decodes to all-zero controls).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  32  instruction memory address; combinational, equals pc_f.
- imem_rdata  in  32  instruction word at imem_addr; combinational read, valid in the same cycle.
- stall_f  in  1  hazard unit: hold PC.
- stall_d  in  1  hazard unit: hold IF/ID.
- flush_d  in  1  hazard unit: bubble IF/ID.
- jump_d  in  1  JumpD from decode for instr_d.
- jump_target_d  in  32  jump target computed in decode.
- redirect_e  in  1  taken branch resolved in EX.
- redirect_target_e  in  32  branch target from EX.
- pc_f  out  32  current fetch PC (registered).
- instr_d  out  32  IF/ID instruction, drives decode instruction_code.
- pc_plus4_d  out  32  IF/ID PC+4 of instr_d.
- valid_d  out  1  IF/ID holds a real instruction.
- misalign_err  out  1  sticky: a redirect or jump target had bits [1:0] != 0.
- fetch_count  out  32  count of instructions written into IF/ID.

Behaviour:
- Reset (async on rst_n low):
  - pc_f = RESET_PC.
  - instr_d = NOP_INSTR, pc_plus4_d = 0, valid_d = 0.
  - misalign_err = 0, fetch_count = 0.
  - On release, the first fetch occurs at RESET_PC on the first rising edge.
  - A reset asserted mid-operation discards all in-flight state immediately.
- Jump qualification: jump_take = jump_d & valid_d & ~stall_d. A jump from a stalled or bubble decode slot is ignored; the stalled jump re-presents next cycle.
- Next PC priority, highest first:
  1. redirect_e: pc_f <= {redirect_target_e[31:2], 2'b00}.
  2. jump_take: pc_f <= {jump_target_d[31:2], 2'b00}.
  3. stall_f: pc_f holds.
  4. Otherwise: pc_f <= pc_f + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirect and jump override stall_f.
- IF/ID register update, highest first:
  1. redirect_e | jump_take | flush_d: bubble (instr_d = NOP_INSTR, pc_plus4_d = 0, valid_d = 0). This overrides stall_d.
  2. stall_d: all IF/ID fields hold.
  3. Otherwise: instr_d <= imem_rdata, pc_plus4_d <= pc_f + 4, valid_d <= 1.
- Latency: a word presented at imem_addr appears on instr_d one edge later.
- Redirect/jump penalty:
  - Jump: 1 bubble.
  - EX redirect: 1 bubble in IF/ID here; the ID/EX flush is owned elsewhere.
- Simultaneous redirect_e and jump_take: redirect_e wins. The jump is on the wrong path and is discarded.
- misalign_err: set on any edge where a taken redirect_e or jump_take target has [1:0] != 2'b00. Cleared only by reset.
- fetch_count: +1 on every edge where IF/ID loads with valid_d <= 1 (rule 3). Wraps at 2^32. Holds on stall and bubble.
- stall_f = 0 with stall_d = 1 is legal: PC advances and the fetched word is dropped. The hazard unit never issues this; no check is required.

Test Plan:
- Reset then 4 free-run cycles with imem_rdata = 32'h2001_0005, stalls/flushes 0 → pc_f = 0, 4, 8, C, 10; valid_d = 1 from cycle 1; fetch_count = 4; pc_plus4_d = 10 at last edge.
- stall_f = stall_d = 1 for 2 cycles at pc_f = 8 → pc_f, instr_d, pc_plus4_d and fetch_count frozen; resume continues at C.
- jump_d = 1, valid_d = 1, jump_target_d = 32'h0000_0040 → next pc_f = 40; instr_d = 0 and valid_d = 0 for one cycle; fetch at 40 lands next. Repeat with stall_d = 1 → no jump taken.
- redirect_e = 1 (target 32'h100) and jump_d = 1 (target 32'h40) in the same cycle → pc_f = 100, IF/ID bubble; repeat with stall_f = 1 → still 100.
- Jump target 32'h0000_0042 → pc_f = 40, misalign_err = 1 and stays 1 through later good jumps until rst_n low.
- pc_f = 32'hFFFF_FFFC free-run → next pc_f = 0, pc_plus4_d = 0, valid_d = 1. Assert rst_n low mid-cycle → outputs at reset values before the next edge.
